// File: rtl/sram_rd_pkg.sv
// Shared types and constants for the SRAM frame reader and its skid FIFO.
package sram_rd_pkg;

    // Reader control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    // Two entries cover one word in flight from the SRAM plus one parked word.
    localparam int SKID_DEPTH = 2;
    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/sram_frame_reader_if.sv
// Output word stream of the SRAM frame reader.
// Handshake: a word transfers on a rising clk edge where out_valid and out_ready
// are both high. Once out_valid is raised, out_valid, out_data and out_last stay
// stable until that transfer; out_ready may change freely and never gates out_valid.
interface sram_frame_reader_if #(
    parameter int WWORD = 32
);
    logic             out_valid;
    logic             out_ready;
    logic [WWORD-1:0] out_data;
    logic             out_last;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/sram_rd_skid.sv
// Two-entry FIFO that parks SRAM read data (plus frame-end flag) so that
// downstream stalls never drop a word already requested from the SRAM.
module sram_rd_skid
    import sram_rd_pkg::*;
#(
    parameter int W = 33
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic [W-1:0]          din,
    input  logic                  pop,
    output logic [W-1:0]          dout,
    output logic [SKID_CNT_W-1:0] count
);

    logic [W-1:0]          mem [SKID_DEPTH];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [SKID_CNT_W-1:0] cnt_q;

    // Storage, pointers and occupancy; push and pop in the same cycle keep the count.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + SKID_CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - SKID_CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Head of the queue is presented directly.
    always_comb begin
        dout  = mem[rd_ptr];
        count = cnt_q;
    end

endmodule

// File: rtl/sram_frame_reader.sv
// Read-side controller for the 1W1R SRAM: streams len words starting at base,
// wrapping at DEPTH, onto a valid/ready stream through a 2-entry skid FIFO.
// Optional feature macro: READER_LOOP_EN (repeat the frame until stop is seen).
module sram_frame_reader
    import sram_rd_pkg::*;
#(
    parameter int WWORD = 32,
    parameter int WADDR = 5,
    parameter int DEPTH = 24
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [WADDR-1:0]          base,
    input  logic [WADDR:0]            len,
    output logic                      busy,
    output logic                      done,
    output logic [WADDR-1:0]          sram_aa,
    output logic                      sram_cena,
    input  logic [WWORD-1:0]          sram_qa,
`ifdef READER_LOOP_EN
    input  logic                      stop,
`endif
    sram_frame_reader_if.master       strm,
    output rd_state_t                 dbg_state
);

    rd_state_t             state_q, state_d;
    logic [WADDR-1:0]      addr_q, addr_d;
    logic [WADDR:0]        rem_q, rem_d;
    logic                  inflight_q;
    logic                  inflight_last_q;
    logic                  done_q, done_d;
    logic                  issue;
    logic                  frame_end;
    logic                  pop;
    logic                  room;
    logic [WADDR-1:0]      base_eff;
    logic [SKID_CNT_W-1:0] fifo_cnt;
    logic [SKID_CNT_W:0]   occ;
    logic [WWORD:0]        fifo_dout;
`ifdef READER_LOOP_EN
    logic [WADDR-1:0]      base_q;
    logic [WADDR:0]        len_q;
    logic                  stop_seen_q;
`endif

    // Out-of-range base addresses restart at the bottom of the SRAM.
    assign base_eff = (32'(base) >= DEPTH) ? '0 : base;

    // Handshake and issue headroom: words held + in flight, minus the one leaving now.
    always_comb begin
        pop  = strm.out_valid & strm.out_ready;
        occ  = {1'b0, fifo_cnt} + {{SKID_CNT_W{1'b0}}, inflight_q};
        room = pop ? (occ <= (SKID_CNT_W+1)'(2)) : (occ <= (SKID_CNT_W+1)'(1));
    end

    // Next state, next address/count, read issue and done generation.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        done_d    = 1'b0;
        issue     = 1'b0;
        frame_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d = base_eff;
                    rem_d  = len;
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (room) begin
                    issue     = 1'b1;
                    frame_end = (rem_q == (WADDR+1)'(1));
                    addr_d    = (32'(addr_q) == DEPTH - 1) ? '0 : addr_q + WADDR'(1);
                    rem_d     = rem_q - (WADDR+1)'(1);
                    if (frame_end) begin
`ifdef READER_LOOP_EN
                        if (!(stop_seen_q || stop)) begin
                            addr_d = base_q;
                            rem_d  = len_q;
                        end else begin
                            state_d = DRAIN;
                        end
`else
                        state_d = DRAIN;
`endif
                    end
                end
            end
            DRAIN: begin
                // Nothing more is issued, so the only word left leaving ends the run.
                if (pop && fifo_cnt == SKID_CNT_W'(1) && !inflight_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; the SRAM returns data one cycle after each issue.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            inflight_q      <= issue;
            inflight_last_q <= frame_end;
            done_q          <= done_d;
        end
    end

`ifdef READER_LOOP_EN
    // Frame parameters for reload, and a sticky stop request for the current run.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            base_q      <= '0;
            len_q       <= '0;
            stop_seen_q <= 1'b0;
        end else if (state_q == IDLE) begin
            stop_seen_q <= 1'b0;
            if (start) begin
                base_q <= base_eff;
                len_q  <= len;
            end
        end else if (stop) begin
            stop_seen_q <= 1'b1;
        end
    end
`endif

    sram_rd_skid #(
        .W (WWORD + 1)
    ) u_skid (
        .clk   (clk),
        .rstn  (rstn),
        .push  (inflight_q),
        .din   ({inflight_last_q, sram_qa}),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_cnt)
    );

    // Output wiring; out_last is qualified so stale FIFO contents never show it.
    always_comb begin
        sram_aa        = addr_q;
        sram_cena      = ~issue;
        busy           = (state_q != IDLE);
        done           = done_q;
        dbg_state      = state_q;
        strm.out_valid = (fifo_cnt != '0);
        strm.out_data  = fifo_dout[WWORD-1:0];
        strm.out_last  = strm.out_valid & fifo_dout[WWORD];
    end

endmodule
